// File: rtl/vga_hex_display_renderer_if.sv
// Pixel/overlay bus of the hex display renderer: pixel coordinate, digit origin,
// value load and frame timing in, registered 'show' bit out.
interface vga_hex_display_renderer_if #(
    parameter int DIGITS  = 4,
    parameter int COORD_W = 11
);
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic                frame_start;
    logic [COORD_W-1:0]  origin_x;
    logic [COORD_W-1:0]  origin_y;
    logic [4*DIGITS-1:0] value;
    logic                value_valid;
    logic                lz_blank;
    logic [DIGITS-1:0]   blink_mask;
    logic                show;

    modport master (
        output x, y, frame_start, origin_x, origin_y, value, value_valid, lz_blank, blink_mask,
        input  show
    );

    modport slave (
        input  x, y, frame_start, origin_x, origin_y, value, value_valid, lz_blank, blink_mask,
        output show
    );
endinterface

// File: rtl/vga_hex_display_renderer.sv
// Two-stage pipelined multi-digit 7-segment hex overlay with frame-synchronous double buffering.
// Define VGA_DIGIT_BLINK_EN to build the per-digit blink frame counter.
module vga_hex_display_renderer #(
    parameter int DIGITS     = 4,
    parameter int COORD_W    = 11,
    parameter int SEG_LEN    = 10,
    parameter int SEG_T      = 5,
    parameter int PITCH      = 48,
    parameter int BLINK_LOG2 = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    vga_hex_display_renderer_if.slave    bus
);
    localparam int W2    = COORD_W + 2;
    localparam int KW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BOX_X = SEG_LEN + 2 * SEG_T;
    localparam int BOX_Y = 2 * SEG_LEN + SEG_T;
    localparam logic signed [W2-1:0] BX = W2'(BOX_X);
    localparam logic signed [W2-1:0] BY = W2'(BOX_Y);

    logic [4*DIGITS-1:0] r_shadow, r_disp, w_disp_next;
    logic [DIGITS-1:0]   r_blank, w_blank_next, w_dark;
    logic                w_zero_run;

    // NOTE: every always_comb assigns its outputs a default first so no latch is inferred.
    always_comb begin
        w_disp_next  = bus.value_valid ? bus.value : r_shadow;
        w_blank_next = '0;
        w_zero_run   = 1'b1;
        for (int i = 0; i < DIGITS - 1; i++) begin
            w_zero_run      = w_zero_run & (w_disp_next[4*(DIGITS-1-i) +: 4] == 4'h0);
            w_blank_next[i] = bus.lz_blank & w_zero_run;
        end
    end

    // NOTE: asynchronous reset clears every register, pipeline included, so in-flight pixels are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_disp   <= '0;
            r_blank  <= '0;
        end else begin
            if (bus.value_valid) r_shadow <= bus.value;
            if (bus.frame_start) begin
                r_disp  <= w_disp_next;
                r_blank <= w_blank_next;
            end
        end
    end

`ifdef VGA_DIGIT_BLINK_EN
    logic [BLINK_LOG2-1:0] r_frame_cnt;
    logic [DIGITS-1:0]     r_blink_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt  <= '0;
            r_blink_mask <= '0;
        end else if (bus.frame_start) begin
            r_frame_cnt  <= r_frame_cnt + 1'b1;
            r_blink_mask <= bus.blink_mask;
        end
    end

    assign w_dark = r_frame_cnt[BLINK_LOG2-1] ? r_blink_mask : '0;
`else
    localparam int unused_blink_log2 = BLINK_LOG2;
    logic w_unused_blink;
    assign w_unused_blink = ^bus.blink_mask;
    assign w_dark         = '0;
`endif

    // Stage 1: offset from origin, nearest digit by threshold chain, bounding-box test.
    logic signed [W2-1:0] w_dx, w_dy, w_dxl;
    logic [KW-1:0]        w_k;
    logic                 w_in_box;

    always_comb begin
        w_dx  = $signed({2'b00, bus.x}) - $signed({2'b00, bus.origin_x});
        w_dy  = $signed({2'b00, bus.y}) - $signed({2'b00, bus.origin_y});
        w_k   = '0;
        w_dxl = w_dx;
        for (int i = 1; i < DIGITS; i++) begin
            if (w_dx >= $signed(W2'(i * PITCH - PITCH / 2))) begin
                w_k   = KW'(i);
                w_dxl = w_dx - $signed(W2'(i * PITCH));
            end
        end
        w_in_box = (w_dxl >= -BX) && (w_dxl <= BX) && (w_dy >= -BY) && (w_dy <= BY);
    end

    logic [KW-1:0]        r_k;
    logic signed [W2-1:0] r_dx, r_dy;
    logic                 r_in_box, r_show;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k      <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_in_box <= 1'b0;
        end else begin
            r_k      <= w_k;
            r_dx     <= w_dxl;
            r_dy     <= w_dy;
            r_in_box <= w_in_box;
        end
    end

    // Stage 2: digit lookup, blanking, segment decode and hit test.
    function automatic logic seg_hit(input logic signed [W2-1:0] px, input logic signed [W2-1:0] py,
                                     input int sx, input int sy, input int hx, input int hy);
        int ddx, ddy;
        ddx = int'(px) - sx;
        ddy = int'(py) - sy;
        return (ddx >= -hx) && (ddx <= hx) && (ddy >= -hy) && (ddy <= hy);
    endfunction

    logic [3:0] w_nib;
    logic       w_off;
    logic [6:0] w_seg, w_hit;  // {a,b,c,d,e,f,g}
    logic       w_show_next;

    always_comb begin
        w_nib = 4'h0;
        w_off = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_k == KW'(i)) begin
                w_nib = r_disp[4*(DIGITS-1-i) +: 4];
                w_off = r_blank[i] | w_dark[i];
            end
        end
        unique case (w_nib)
            4'h0: w_seg = 7'h7E;  4'h1: w_seg = 7'h30;  4'h2: w_seg = 7'h6D;  4'h3: w_seg = 7'h79;
            4'h4: w_seg = 7'h33;  4'h5: w_seg = 7'h5B;  4'h6: w_seg = 7'h5F;  4'h7: w_seg = 7'h70;
            4'h8: w_seg = 7'h7F;  4'h9: w_seg = 7'h7B;  4'hA: w_seg = 7'h77;  4'hB: w_seg = 7'h1F;
            4'hC: w_seg = 7'h4E;  4'hD: w_seg = 7'h3D;  4'hE: w_seg = 7'h4F;  default: w_seg = 7'h47;
        endcase
        w_hit[6] = seg_hit(r_dx, r_dy, 0, -2 * SEG_LEN, SEG_LEN, SEG_T);
        w_hit[5] = seg_hit(r_dx, r_dy, SEG_LEN + SEG_T, -SEG_LEN, SEG_T, SEG_LEN);
        w_hit[4] = seg_hit(r_dx, r_dy, SEG_LEN + SEG_T, SEG_LEN, SEG_T, SEG_LEN);
        w_hit[3] = seg_hit(r_dx, r_dy, 0, 2 * SEG_LEN, SEG_LEN, SEG_T);
        w_hit[2] = seg_hit(r_dx, r_dy, -SEG_LEN - SEG_T, SEG_LEN, SEG_T, SEG_LEN);
        w_hit[1] = seg_hit(r_dx, r_dy, -SEG_LEN - SEG_T, -SEG_LEN, SEG_T, SEG_LEN);
        w_hit[0] = seg_hit(r_dx, r_dy, 0, 0, SEG_LEN, SEG_T);
        w_show_next = r_in_box & ~w_off & (|(w_seg & w_hit));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_show <= 1'b0;
        else        r_show <= w_show_next;
    end

    assign bus.show = r_show;
endmodule

// File: tb/tb_vga_hex_display_renderer.sv
// Self-checking bench for vga_hex_display_renderer: directed vectors plus randomized pixels
// compared against a geometric reference model of the seven-segment glyphs.
module tb_vga_hex_display_renderer;
    localparam int DIGITS = 4, COORD_W = 11, SEG_LEN = 10, SEG_T = 5, PITCH = 48, BLINK_LOG2 = 5;
    localparam int L = SEG_LEN, T = SEG_T;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_hex_display_renderer_if #(.DIGITS(DIGITS), .COORD_W(COORD_W)) bus();

    vga_hex_display_renderer #(
        .DIGITS(DIGITS), .COORD_W(COORD_W), .SEG_LEN(SEG_LEN), .SEG_T(SEG_T),
        .PITCH(PITCH), .BLINK_LOG2(BLINK_LOG2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: show=%b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: glyphs as lists of lit segment letters, tested as rectangles.
    string glyph[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    logic [15:0] m_shadow, m_disp;
    bit          m_blank[DIGITS];
    int          m_cnt;
    logic [3:0]  m_bmask;

    function automatic bit lit(input int nib, input byte s);
        for (int j = 0; j < glyph[nib].len(); j++)
            if (glyph[nib][j] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_rect(input int px, input int py, input int sx, input int sy,
                                   input int hx, input int hy);
        int ax, ay;
        ax = (px > sx) ? px - sx : sx - px;
        ay = (py > sy) ? py - sy : sy - py;
        return (ax <= hx) && (ay <= hy);
    endfunction

    function automatic bit model_show(input int px, input int py, input int ox, input int oy);
        int nib, cx, cy;
        bit dark;
        for (int i = 0; i < DIGITS; i++) begin
            nib  = int'(m_disp[4*(DIGITS-1-i) +: 4]);
            dark = 1'b0;
`ifdef VGA_DIGIT_BLINK_EN
            dark = (m_cnt >= (1 << (BLINK_LOG2 - 1))) && m_bmask[i];
`endif
            if (m_blank[i] || dark) continue;
            cx = ox + i * PITCH;
            cy = oy;
            if (lit(nib, "a") && in_rect(px, py, cx, cy - 2 * L, L, T)) return 1'b1;
            if (lit(nib, "d") && in_rect(px, py, cx, cy + 2 * L, L, T)) return 1'b1;
            if (lit(nib, "g") && in_rect(px, py, cx, cy, L, T)) return 1'b1;
            if (lit(nib, "b") && in_rect(px, py, cx + L + T, cy - L, T, L)) return 1'b1;
            if (lit(nib, "c") && in_rect(px, py, cx + L + T, cy + L, T, L)) return 1'b1;
            if (lit(nib, "f") && in_rect(px, py, cx - L - T, cy - L, T, L)) return 1'b1;
            if (lit(nib, "e") && in_rect(px, py, cx - L - T, cy + L, T, L)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_shadow = '0;
        m_disp   = '0;
        m_cnt    = 0;
        m_bmask  = '0;
        foreach (m_blank[i]) m_blank[i] = 1'b0;
    endtask

    task automatic model_ctrl();
        bit zero;
        if (bus.frame_start) begin
            m_disp = bus.value_valid ? bus.value : m_shadow;
            zero   = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                zero       = zero && (m_disp[4*(DIGITS-1-i) +: 4] == 4'h0);
                m_blank[i] = bus.lz_blank && zero && (i != DIGITS - 1);
            end
            m_cnt   = (m_cnt + 1) % (1 << BLINK_LOG2);
            m_bmask = bus.blink_mask;
        end
        if (bus.value_valid) m_shadow = bus.value;
    endtask

    typedef struct {
        bit    chk;
        bit    exp;
        string name;
    } pend_t;
    pend_t q[$];

    // One pixel per clock: drive at negedge, compare the result of the pixel two clocks back.
    task automatic cycle(input int x, input int y, input bit use_model, input bit chk,
                         input bit exp, input string name);
        pend_t e, o;
        bus.x = COORD_W'(x);
        bus.y = COORD_W'(y);
        model_ctrl();
        e.chk  = chk;
        e.exp  = use_model ? model_show(int'(bus.x), int'(bus.y), int'(bus.origin_x), int'(bus.origin_y)) : exp;
        e.name = name;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.frame_start = 1'b0;
        bus.value_valid = 1'b0;
        @(negedge clk);
        if (q.size() == 2) begin
            o = q.pop_front();
            if (o.chk) check(o.name, bus.show, o.exp);
        end
    endtask

    task automatic flush();
        cycle(2000, 2000, 1'b1, 1'b1, 1'b0, "flush");
        cycle(2000, 2000, 1'b1, 1'b1, 1'b0, "flush");
    endtask

    task automatic load(input logic [15:0] v, input bit with_frame);
        bus.value       = v;
        bus.value_valid = 1'b1;
        bus.frame_start = with_frame;
    endtask

    typedef struct {
        int    x;
        int    y;
        bit    exp;
        string name;
    } vec_t;
    vec_t geo[12];

    initial begin
        int ox, oy, x, y;
        geo[0]  = '{100, 100, 1'b1, "geo_centre_g"};
        geo[1]  = '{100, 106, 1'b0, "geo_gap_g_d"};
        geo[2]  = '{148, 100, 1'b0, "geo_digit1_g_dark"};
        geo[3]  = '{100,  80, 1'b1, "geo_seg_a"};
        geo[4]  = '{ 85,  90, 1'b1, "geo_seg_f"};
        geo[5]  = '{ 80,  90, 1'b1, "geo_f_left_edge"};
        geo[6]  = '{ 79,  90, 1'b0, "geo_left_of_f"};
        geo[7]  = '{120, 110, 1'b1, "geo_c_right_edge"};
        geo[8]  = '{121, 110, 1'b0, "geo_right_of_c"};
        geo[9]  = '{100, 125, 1'b1, "geo_d_bottom_edge"};
        geo[10] = '{100, 126, 1'b0, "geo_below_d"};
        geo[11] = '{244,  80, 1'b1, "geo_digit3_a"};

        bus.x = '0; bus.y = '0; bus.frame_start = 1'b0; bus.origin_x = 11'd100; bus.origin_y = 11'd100;
        bus.value = '0; bus.value_valid = 1'b0; bus.lz_blank = 1'b0; bus.blink_mask = '0;
        model_reset();

        // Reset held for 3 clocks with arbitrary pixels.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.x = COORD_W'($urandom);
            bus.y = COORD_W'($urandom);
            #1 check("reset_show", bus.show, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // First frame with value 0: four '0' glyphs.
        bus.frame_start = 1'b1;
        cycle(100,  80, 1'b0, 1'b1, 1'b1, "zero_d0_a");
        cycle(100, 100, 1'b0, 1'b1, 1'b0, "zero_d0_g_dark");
        cycle(148,  80, 1'b0, 1'b1, 1'b1, "zero_d1_a");
        cycle(196,  80, 1'b0, 1'b1, 1'b1, "zero_d2_a");
        cycle(244,  80, 1'b0, 1'b1, 1'b1, "zero_d3_a");
        cycle(244, 100, 1'b0, 1'b1, 1'b0, "zero_d3_g_dark");
        flush();

        // Geometry with disp = 8000.
        load(16'h8000, 1'b1);
        cycle(2000, 2000, 1'b1, 1'b1, 1'b0, "load_8000");
        foreach (geo[i]) cycle(geo[i].x, geo[i].y, 1'b0, 1'b1, geo[i].exp, geo[i].name);
        flush();
        for (int yy = 60; yy <= 140; yy += 5)
            for (int xx = 60; xx <= 260; xx += 3)
                cycle(xx, yy, 1'b1, 1'b1, 1'b0, "scan_8000");
        flush();

        // Tear-free update, then simultaneous load and frame start.
        load(16'h1234, 1'b0);
        cycle(100, 100, 1'b0, 1'b1, 1'b1, "tear_old_still_8");
        cycle(148, 100, 1'b0, 1'b1, 1'b0, "tear_old_still_0");
        bus.frame_start = 1'b1;
        cycle(100, 100, 1'b0, 1'b1, 1'b0, "tear_new_1_no_g");
        cycle(115,  90, 1'b0, 1'b1, 1'b1, "tear_new_1_seg_b");
        cycle(148, 100, 1'b0, 1'b1, 1'b1, "tear_new_2_seg_g");
        load(16'h8000, 1'b1);
        cycle(100, 100, 1'b0, 1'b1, 1'b1, "bypass_8_visible");
        bus.frame_start = 1'b1;
        cycle(100, 100, 1'b0, 1'b1, 1'b1, "bypass_shadow_kept");
        flush();

        // Leading-zero blanking.
        bus.lz_blank = 1'b1;
        load(16'h0040, 1'b1);
        cycle(100,  80, 1'b0, 1'b1, 1'b0, "lz_d0_blank");
        cycle(148,  80, 1'b0, 1'b1, 1'b0, "lz_d1_blank");
        cycle(196, 100, 1'b0, 1'b1, 1'b1, "lz_d2_4_seg_g");
        cycle(196,  80, 1'b0, 1'b1, 1'b0, "lz_d2_4_no_a");
        cycle(244,  80, 1'b0, 1'b1, 1'b1, "lz_d3_0_seg_a");
        load(16'h0000, 1'b1);
        cycle(196,  80, 1'b0, 1'b1, 1'b0, "lz_all0_d2_blank");
        cycle(244,  80, 1'b0, 1'b1, 1'b1, "lz_all0_d3_shown");
        cycle(100,  80, 1'b0, 1'b1, 1'b0, "lz_all0_d0_blank");
        flush();
        bus.lz_blank = 1'b0;

        // Clipping near the origin and far edge.
        bus.origin_x = 11'd5;
        bus.origin_y = 11'd5;
        load(16'h8888, 1'b1);
        cycle(   0,    0, 1'b0, 1'b1, 1'b1, "clip_00_lit");
        cycle(2047,    0, 1'b0, 1'b1, 1'b0, "clip_x2047");
        cycle(2047,    5, 1'b0, 1'b1, 1'b0, "clip_x2047_y5");
        cycle(   0, 2047, 1'b0, 1'b1, 1'b0, "clip_y2047");
        cycle(2047, 2047, 1'b0, 1'b1, 1'b0, "clip_far_corner");
        flush();

        // Blink mask across several frames (steady unless the blink build is selected).
        bus.origin_x = 11'd100;
        bus.origin_y = 11'd100;
        bus.blink_mask = 4'b0001;
        for (int f = 0; f < 6; f++) begin
            bus.frame_start = 1'b1;
            cycle(100, 100, 1'b1, 1'b1, 1'b0, "blink_d0");
            cycle(244, 100, 1'b1, 1'b1, 1'b0, "blink_d3");
        end
        flush();

        // Randomized pixels, origins and updates against the model.
        for (int n = 0; n < 3000; n++) begin
            if (n % 50 == 0) begin
                ox = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 2047));
                oy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 2047));
                bus.origin_x = COORD_W'(ox);
                bus.origin_y = COORD_W'(oy);
            end
            if ($urandom_range(0, 39) == 0) begin
                bus.value       = 16'($urandom);
                if ($urandom_range(0, 1) == 0) bus.value[15:8] = 8'h00;
                bus.value_valid = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) begin
                bus.frame_start = 1'b1;
                bus.lz_blank    = 1'($urandom);
                bus.blink_mask  = 4'($urandom);
            end
            x = ox - 30 + int'($urandom_range(0, 4 * PITCH + 60));
            y = oy - 35 + int'($urandom_range(0, 70));
            cycle(x & 2047, y & 2047, 1'b1, 1'b1, 1'b0, "random");
        end
        flush();

        // Asynchronous reset while a lit pixel is in flight.
        bus.blink_mask = '0;
        bus.lz_blank   = 1'b0;
        bus.origin_x   = 11'd100;
        bus.origin_y   = 11'd100;
        load(16'h8888, 1'b1);
        cycle(100, 100, 1'b0, 1'b1, 1'b1, "pre_reset_lit");
        cycle(100, 100, 1'b0, 1'b1, 1'b1, "pre_reset_lit");
        check("pre_reset_show_high", bus.show, 1'b1);
        rst_n = 1'b0;
        #1 check("async_reset_show", bus.show, 1'b0);
        q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(100, 100, 1'b0, 1'b1, 1'b0, "post_reset_disp0_g_dark");
        cycle(100,  80, 1'b0, 1'b1, 1'b1, "post_reset_disp0_a");
        flush();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
